npu_result_buffer: RTL and testbench
====================================

# npu_result_buffer

Output-side result FIFO of the NPU load unit. It accepts result vectors from the NPU datapath and serves them to the external consumer (host shim or self-tester) through the read, ready and used-words interface. It also maintains the running result count. It is the producer end of the read protocol the self-tester drains: the tester polls `o_usedw`, issues `i_rd_en`, and compares `o_rd_dout` against golden data.

## Interface
Parameters:
- `DATAW`, default `` `DOTW*`ACCW ``: result word width.
- `DEPTH`, default `` `OUTPUT_BUFFER_SIZE ``: RAM entries. Must be a power of two, ≥4. Usable capacity is DEPTH-1.
- `ADDRW`, default `$clog2(DEPTH)`: pointer and usedw width.
- `AFULL_MARGIN`, default 8: almost-full slack, in entries.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `i_wr_en`, in, 1: datapath write request.
- `i_wr_data`, in, DATAW: result word.
- `o_wr_rdy`, out, 1: buffer can accept a write this cycle.
- `o_almost_full`, out, 1: occupancy ≥ DEPTH-1-AFULL_MARGIN. The datapath stalls issue on this.
- `i_rd_en`, in, 1: consumer read request.
- `o_rd_rdy`, out, 1: buffer non-empty.
- `o_rd_dout`, out, DATAW: read data.
- `o_rd_valid`, out, 1: one-cycle pulse when `o_rd_dout` carries a newly read word.
- `o_usedw`, out, ADDRW: current occupancy, 0..DEPTH-1.
- `o_result_count`, out, 32: total words accepted since reset.
- `o_overflow`, out, 1: sticky flag, set by a write attempted while full.
- `o_underflow`, out, 1: sticky flag, set by a read attempted while empty.

## Operation
- Circular buffer with write pointer `wp` and read pointer `rp`, each ADDRW bits, wrapping modulo DEPTH.
  - Occupancy is held in a registered counter `cnt`.
  - full = (cnt == DEPTH-1); empty = (cnt == 0).
- Write accept: `i_wr_en && o_wr_rdy`.
  - RAM[wp] ← `i_wr_data`.
  - wp increments.
  - `o_result_count` increments, wrapping at 2^32.
- Write while `!o_wr_rdy`: the data is dropped, pointers and count are unchanged, and `o_overflow` is set to 1 until reset.
- Read accept: `i_rd_en && o_rd_rdy`.
  - rp increments.
  - The word at the old rp appears on `o_rd_dout` the next cycle, with `o_rd_valid`=1 for that cycle.
- Read while empty: no pointer change, `o_rd_dout` holds its value, `o_rd_valid`=0, and `o_underflow` is set to 1 until reset.
- Simultaneous accepted read and write: `cnt` is unchanged and both pointers advance.
- No fall-through: a write and a read in the same cycle on an empty buffer is a read-while-empty (underflow). The written word stays buffered.
- Same-address read/write cannot occur, because capacity is DEPTH-1.
- `cnt` update rule: `cnt_next` = cnt + wr_acc - rd_acc. It never leaves the range 0..DEPTH-1.
- Control outputs are derived from `cnt_next` and registered:
  - `o_wr_rdy` = (`cnt_next` != DEPTH-1).
  - `o_rd_rdy` = (`cnt_next` != 0).
  - `o_almost_full` = (`cnt_next` ≥ DEPTH-1-AFULL_MARGIN).
  - `o_usedw` = `cnt`.
- Reset mid-operation: all contents are discarded, both pointers return to 0, the count is cleared, and the sticky flags are cleared.

## Timing
- Reset values, driven while `reset` is high and on the first cycle after:
  - `o_wr_rdy`=0 while `reset` is high, 1 on the first cycle after.
  - `o_rd_rdy`=0, `o_almost_full`=0, `o_usedw`=0, `o_result_count`=0, `o_overflow`=0, `o_underflow`=0.
  - `o_rd_dout`=0, `o_rd_valid`=0.
- Write-to-readable latency is 1 cycle. A write accepted at edge N gives `o_rd_rdy`=1 and `o_usedw`=1 after edge N.
- Read latency is 1 cycle. `i_rd_en` sampled at edge N gives `o_rd_dout` and `o_rd_valid` valid after edge N.
- Back-to-back reads at full rate are supported. One word is output per cycle while non-empty.
- Ready flags are registered and reflect the accept at the same edge. A producer issuing `i_wr_en` on every cycle where `o_wr_rdy`=1 never overflows.
- A consumer that reads only while `o_usedw` ≥ k and has k-1 reads in flight never underflows.

## Structure
- Shared package `npu_pkg`: holds `DATAW` and `DEPTH` defaults (derived from `` `DOTW ``, `` `ACCW ``, `` `OUTPUT_BUFFER_SIZE ``) and the AFULL margin constant.
- Sub-module `result_sdp_ram`: simple dual-port RAM, one write port and one read port, registered read with 1-cycle latency, no read-during-write bypass.
- Pointer, count, flag and counter logic sit in the top module.

## Test plan
The bench uses DEPTH=8, AFULL_MARGIN=2, DATAW=16.
- Reset, then write 0x0001..0x0003, then read 3 times back to back. The outputs must be:
  - `o_rd_dout` = 0x0001, 0x0002, 0x0003 on consecutive cycles, with `o_rd_valid` high on each.
  - `o_usedw` steps 3→2→1→0.
  - `o_rd_rdy` falls after the third read.
- Write 7 words with `i_wr_en` held high for a further 2 cycles:
  - `o_wr_rdy` is 0 after the 7th accept.
  - `o_almost_full` is 1 from the 5th accept.
  - `o_overflow` is 1.
  - `o_result_count` = 7.
  - Readback shows exactly the 7 original words.
- Read on an empty buffer, with a simultaneous write of 0xABCD:
  - `o_underflow` is 1 and `o_rd_valid` is 0.
  - `o_usedw` is 1.
  - The next read returns 0xABCD.
- Run 20 cycles of simultaneous read and write at occupancy 4: `o_usedw` stays at 4, there is no flag change, data comes out in order, and the pointers wrap past 7 cleanly.
- Assert `reset` at occupancy 5 with the flags set: on the cycle after `reset` deasserts, all outputs are at their reset values and `o_wr_rdy` is 1.
- Drive a self-tester-style drain (read only while `o_usedw` ≥ 3) over 100 random-gap writes: zero underflow, zero overflow, `o_result_count` = 100, and an in-order match.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU sizing constants. The result buffer takes its default width and
// depth from the dot-product geometry.
`ifndef DOTW
`define DOTW 4
`endif
`ifndef ACCW
`define ACCW 32
`endif
`ifndef OUTPUT_BUFFER_SIZE
`define OUTPUT_BUFFER_SIZE 512
`endif

package npu_pkg;
    localparam int RB_DATAW        = `DOTW * `ACCW;
    localparam int RB_DEPTH        = `OUTPUT_BUFFER_SIZE;
    localparam int RB_AFULL_MARGIN = 8;
endpackage

// File: rtl/npu_result_buffer_if.sv
// Write, read and status bundle between the datapath, the result buffer and
// the consumer.
interface npu_result_buffer_if #(
    parameter int DATAW = 16,
    parameter int ADDRW = 3
);
    logic             i_wr_en;
    logic [DATAW-1:0] i_wr_data;
    logic             o_wr_rdy;
    logic             o_almost_full;
    logic             i_rd_en;
    logic             o_rd_rdy;
    logic [DATAW-1:0] o_rd_dout;
    logic             o_rd_valid;
    logic [ADDRW-1:0] o_usedw;
    logic [31:0]      o_result_count;
    logic             o_overflow;
    logic             o_underflow;

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en,
        output o_wr_rdy, o_almost_full, o_rd_rdy, o_rd_dout, o_rd_valid,
               o_usedw, o_result_count, o_overflow, o_underflow
    );

    modport master (
        output i_wr_en, i_wr_data, i_rd_en,
        input  o_wr_rdy, o_almost_full, o_rd_rdy, o_rd_dout, o_rd_valid,
               o_usedw, o_result_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/npu_result_buffer_ram.sv
// Simple dual-port RAM with a registered read port. There is no read-during-write
// bypass; the buffer never reads the address it is writing.
module result_sdp_ram #(
    parameter int DATAW = 16,
    parameter int DEPTH = 8,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);
    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Only the output register is reset so the read port shows 0 after reset.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/npu_result_buffer.sv
// Output-side result FIFO: circular buffer over result_sdp_ram with registered
// ready/almost-full flags, sticky error flags and a running result count.
module npu_result_buffer
    import npu_pkg::*;
#(
    parameter int DATAW        = RB_DATAW,
    parameter int DEPTH        = RB_DEPTH,
    parameter int ADDRW        = $clog2(DEPTH),
    parameter int AFULL_MARGIN = RB_AFULL_MARGIN
) (
    input  logic               clk,
    input  logic               reset,
    npu_result_buffer_if.slave bus
);
    localparam logic [ADDRW-1:0] FULL_CNT  = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW-1:0] AFULL_CNT = ADDRW'(DEPTH - 1 - AFULL_MARGIN);
    localparam logic [ADDRW-1:0] ONE       = ADDRW'(1);

    logic [ADDRW-1:0] wp, rp, cnt, cnt_next;
    logic             wr_rdy_q, rd_rdy_q, afull_q;
    logic             ovf_q, udf_q, rd_valid_q;
    logic [31:0]      result_count;
    logic             wr_rdy, wr_acc, rd_acc;

    // Ready is held high internally during reset and masked here, so it reads 0
    // while reset is asserted and 1 immediately after release.
    assign wr_rdy = wr_rdy_q & ~reset;
    assign wr_acc = bus.i_wr_en & wr_rdy;
    assign rd_acc = bus.i_rd_en & rd_rdy_q;

    always_comb begin
        cnt_next = cnt;
        if (wr_acc && !rd_acc)
            cnt_next = cnt + ONE;
        else if (rd_acc && !wr_acc)
            cnt_next = cnt - ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp           <= '0;
            rp           <= '0;
            cnt          <= '0;
            wr_rdy_q     <= 1'b1;
            rd_rdy_q     <= 1'b0;
            afull_q      <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            result_count <= '0;
        end else begin
            if (wr_acc) begin
                wp           <= wp + ONE;
                result_count <= result_count + 32'd1;
            end
            if (rd_acc)
                rp <= rp + ONE;
            cnt        <= cnt_next;
            wr_rdy_q   <= (cnt_next != FULL_CNT);
            rd_rdy_q   <= (cnt_next != '0);
            afull_q    <= (cnt_next >= AFULL_CNT);
            rd_valid_q <= rd_acc;
            if (bus.i_wr_en && !wr_rdy)
                ovf_q <= 1'b1;
            if (bus.i_rd_en && !rd_rdy_q)
                udf_q <= 1'b1;
        end
    end

    result_sdp_ram #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wp),
        .wdata (bus.i_wr_data),
        .re    (rd_acc),
        .raddr (rp),
        .rdata (bus.o_rd_dout)
    );

    assign bus.o_wr_rdy       = wr_rdy;
    assign bus.o_rd_rdy       = rd_rdy_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_rd_valid     = rd_valid_q;
    assign bus.o_usedw        = cnt;
    assign bus.o_result_count = result_count;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = udf_q;
endmodule

// File: tb/tb_npu_result_buffer.sv
// Directed bench for npu_result_buffer at DEPTH=8, AFULL_MARGIN=2, DATAW=16:
// a vector table for the basic sequences plus hand-written streaming, reset and drain runs.
module tb_npu_result_buffer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    npu_result_buffer_if #(.DATAW(16), .ADDRW(3)) bus ();

    npu_result_buffer #(
        .DATAW        (16),
        .DEPTH        (8),
        .ADDRW        (3),
        .AFULL_MARGIN (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst, wr, rd;
        logic [15:0] wd;
        logic        wr_rdy, rd_rdy, af;
        logic [2:0]  usedw;
        logic        vld;
        logic [15:0] dout;
        logic [31:0] cnt;
        logic        ovf, udf;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    logic [15:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic wr, input logic [15:0] wd,
                                input logic rd, input logic wr_rdy, input logic rd_rdy,
                                input logic af, input logic [2:0] uw, input logic vld,
                                input logic [15:0] dout, input logic [31:0] cnt,
                                input logic ovf, input logic udf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.wd = wd; v.rd = rd;
        v.wr_rdy = wr_rdy; v.rd_rdy = rd_rdy; v.af = af; v.usedw = uw;
        v.vld = vld; v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk_all(input string p, input vec_t v);
        chk({p, "_wr_rdy"}, 32'(bus.o_wr_rdy),       32'(v.wr_rdy));
        chk({p, "_rd_rdy"}, 32'(bus.o_rd_rdy),       32'(v.rd_rdy));
        chk({p, "_afull"},  32'(bus.o_almost_full),  32'(v.af));
        chk({p, "_usedw"},  32'(bus.o_usedw),        32'(v.usedw));
        chk({p, "_valid"},  32'(bus.o_rd_valid),     32'(v.vld));
        chk({p, "_dout"},   32'(bus.o_rd_dout),      32'(v.dout));
        chk({p, "_count"},  bus.o_result_count,      v.cnt);
        chk({p, "_ovf"},    32'(bus.o_overflow),     32'(v.ovf));
        chk({p, "_udf"},    32'(bus.o_underflow),    32'(v.udf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int written, got;
        logic exp_vld;

        // rst wr wd rd | wr_rdy rd_rdy af usedw vld dout cnt ovf udf
        vecs.push_back(mk(0, 1, 16'h0001, 0, 1, 1, 0, 3'd1, 0, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0002, 0, 1, 1, 0, 3'd2, 0, 16'h0000, 2, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0003, 0, 1, 1, 0, 3'd3, 0, 16'h0000, 3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 3'd2, 1, 16'h0001, 3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 0, 3'd1, 1, 16'h0002, 3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 3'd0, 1, 16'h0003, 3, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 3'd0, 0, 16'h0003, 3, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 16'h0000, 0, 0, 0));
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(0, 1, 16'(16'h0010 + k), 0, k != 7, 1, k >= 5, 3'(k), 0,
                              16'h0000, 32'(k), 0, 0));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0, 1, 16'h00EE, 0, 0, 1, 1, 3'd7, 0, 16'h0000, 7, 1, 0));
        for (int j = 1; j <= 7; j++)
            vecs.push_back(mk(0, 0, 16'h0000, 1, 1, j != 7, j <= 2, 3'(7 - j), 1,
                              16'(16'h0010 + j), 7, 1, 0));
        vecs.push_back(mk(0, 1, 16'hABCD, 1, 1, 1, 0, 3'd1, 0, 16'h0017, 8, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 3'd0, 1, 16'hABCD, 8, 1, 1));

        bus.i_wr_en = 0; bus.i_wr_data = '0; bus.i_rd_en = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst", mk(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 16'h0000, 0, 0, 0));
        reset = 0;
        @(posedge clk); #1;
        chk("rst_release_wr_rdy", 32'(bus.o_wr_rdy), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset = v.rst; bus.i_wr_en = v.wr; bus.i_wr_data = v.wd; bus.i_rd_en = v.rd;
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), v);
        end
        reset = 0; bus.i_wr_en = 0; bus.i_rd_en = 0;

        // Streaming at occupancy 4; pointers wrap several times.
        for (int i = 0; i < 4; i++) begin
            bus.i_wr_en = 1; bus.i_wr_data = 16'(16'h4000 + i);
            q.push_back(bus.i_wr_data);
            @(posedge clk); #1;
        end
        chk("stream_fill_usedw", 32'(bus.o_usedw), 32'd4);
        for (int i = 0; i < 20; i++) begin
            bus.i_wr_en = 1; bus.i_rd_en = 1; bus.i_wr_data = 16'(16'h4004 + i);
            q.push_back(bus.i_wr_data);
            @(posedge clk); #1;
            chk($sformatf("stream%0d_usedw", i), 32'(bus.o_usedw), 32'd4);
            chk($sformatf("stream%0d_valid", i), 32'(bus.o_rd_valid), 32'd1);
            chk($sformatf("stream%0d_dout", i), 32'(bus.o_rd_dout), 32'(q.pop_front()));
            chk($sformatf("stream%0d_flags", i),
                {30'd0, bus.o_overflow, bus.o_underflow}, 32'd3);
        end

        // Reset at occupancy 5 with both sticky flags set.
        bus.i_rd_en = 0; bus.i_wr_en = 1; bus.i_wr_data = 16'h5555;
        @(posedge clk); #1;
        bus.i_wr_en = 0;
        chk("pre_rst_usedw", 32'(bus.o_usedw), 32'd5);
        chk("pre_rst_afull", 32'(bus.o_almost_full), 32'd1);
        reset = 1;
        @(posedge clk); #1;
        chk("mid_rst_wr_rdy", 32'(bus.o_wr_rdy), 32'd0);
        reset = 0;
        #1;
        chk_all("post_rst", mk(0, 0, 0, 0, 1, 0, 0, 3'd0, 0, 16'h0000, 0, 0, 0));
        @(posedge clk); #1;
        chk("post_rst_idle_wr_rdy", 32'(bus.o_wr_rdy), 32'd1);
        chk("post_rst_idle_usedw", 32'(bus.o_usedw), 32'd0);

        // Self-tester drain: read only while usedw >= 3, then empty the tail.
        q.delete();
        written = 0; got = 0;
        for (int cyc = 0; cyc < 3000 && !(written == 100 && got == 100); cyc++) begin
            bus.i_wr_en   = (written < 100) && bus.o_wr_rdy && ($urandom_range(0, 2) != 0);
            bus.i_wr_data = 16'(16'h6000 + written);
            bus.i_rd_en   = (bus.o_usedw >= 3'd3) || (written == 100 && bus.o_rd_rdy);
            exp_vld = bus.i_rd_en;
            if (bus.i_wr_en) begin
                q.push_back(bus.i_wr_data);
                written++;
            end
            @(posedge clk); #1;
            chk("drain_valid", 32'(bus.o_rd_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk($sformatf("drain_dout%0d", got), 32'(bus.o_rd_dout), 32'(q.pop_front()));
                got++;
            end
        end
        bus.i_wr_en = 0; bus.i_rd_en = 0;
        chk("drain_received", 32'(got), 32'd100);
        chk("drain_count", bus.o_result_count, 32'd100);
        chk("drain_ovf", 32'(bus.o_overflow), 32'd0);
        chk("drain_udf", 32'(bus.o_underflow), 32'd0);
        chk("drain_usedw", 32'(bus.o_usedw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
